mdu_controller: RTL and testbench

//  Sequences the shared iterative multiply/divide unit in the EX stage for MULT, MULTU, DIV and DIVU.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_controller_if.sv | 33 +++
 rtl/mdu_iter_step.sv | 44 ++++
 rtl/mdu_controller.sv | 162 ++++++++++++++++
 tb/tb_mdu_controller.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default sizing.
package mdu_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int ITERS_DEFAULT = WIDTH_DEFAULT;
  localparam int CNT_W_DEFAULT = $clog2(ITERS_DEFAULT);

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_controller_if.sv
// EX-stage <-> MDU signal bundle. The pipeline side is the master; the MDU
// controller is the slave.
interface mdu_controller_if #(
  parameter int WIDTH = 32
);
  import mdu_pkg::*;

  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             mfhi_req;
  logic             mflo_req;
  logic             mthi_we;
  logic             mtlo_we;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, rs_val, rt_val, flush, mfhi_req, mflo_req, mthi_we, mtlo_we,
    input  busy, stall, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, mfhi_req, mflo_req, mthi_we, mtlo_we,
    output busy, stall, done, hi_out, lo_out
  );

endinterface

// File: rtl/mdu_iter_step.sv
// One unsigned iteration of the MDU datapath: shift-add multiply step or
// restoring shift-subtract divide step on magnitudes.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,    // product high half / partial remainder
  input  logic [WIDTH-1:0] opa_i,    // multiplicand / divisor magnitude
  input  logic [WIDTH-1:0] shreg_i,  // multiplier bits / dividend-then-quotient bits
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] addend;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    acc_o   = acc_i;
    shreg_o = shreg_i;

    sum     = {1'b0, acc_i} + {1'b0, opa_i};
    addend  = shreg_i[0] ? sum : {1'b0, acc_i};
    shifted = {acc_i, shreg_i[WIDTH-1]};
    diff    = shifted - {1'b0, opa_i};

    if (is_div_i) begin
      // Remainder stays below the divisor, so diff's top bit is the borrow.
      if (!diff[WIDTH]) begin
        acc_o   = diff[WIDTH-1:0];
        shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o   = shifted[WIDTH-1:0];
        shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o   = addend[WIDTH:1];
      shreg_o = {addend[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_controller.sv
// Sequences the iterative MDU for MULT/MULTU/DIV/DIVU, owns HI/LO and
// generates the EX-stage stall.
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ITERS = ITERS_DEFAULT
) (
  input logic             clk,
  input logic             reset_n,
  mdu_controller_if.slave bus
);

  localparam int CNT_W = $clog2(ITERS);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rs_raw_q, rs_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   step_acc, step_shreg;
  logic               op_signed, op_div, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] product, product_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign op_div    = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
  assign rs_neg    = op_signed & bus.rs_val[WIDTH-1];
  assign rt_neg    = op_signed & bus.rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;

  assign product     = {acc_q, shreg_q};
  assign product_fix = neg_res_q ? -product : product;
  assign quot_fix    = neg_res_q ? -shreg_q : shreg_q;
  assign rem_fix     = neg_rem_q ? -acc_q : acc_q;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opa_i    (opa_q),
    .shreg_i  (shreg_q),
    .acc_o    (step_acc),
    .shreg_o  (step_shreg)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opa_d      = opa_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    rs_raw_d   = rs_raw_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A start always swallows a same-cycle MTHI/MTLO, even when flushed.
        if (bus.start) begin
          if (!bus.flush) begin
            state_d    = CALC;
            cnt_d      = '0;
            acc_d      = '0;
            is_div_d   = op_div;
            opa_d      = op_div ? rt_mag : rs_mag;
            shreg_d    = op_div ? rs_mag : rt_mag;
            rs_raw_d   = bus.rs_val;
            neg_res_d  = rs_neg ^ rt_neg;
            neg_rem_d  = rs_neg;
            div_zero_d = op_div && (bus.rt_val == '0);
          end
        end else begin
          if (bus.mthi_we) hi_d = bus.rs_val;
          if (bus.mtlo_we) lo_d = bus.rs_val;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = step_acc;
          shreg_d = step_shreg;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (div_zero_q) begin
            hi_d = rs_raw_q;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = product_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opa_q      <= '0;
      shreg_q    <= '0;
      acc_q      <= '0;
      rs_raw_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opa_q      <= opa_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      rs_raw_q   <= rs_raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.stall  = bus.busy & (bus.start | bus.mfhi_req | bus.mflo_req |
                                  bus.mthi_we | bus.mtlo_we);
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_mdu_controller.sv
// Directed self-checking bench for mdu_controller: arithmetic, latency,
// stall, flush, reset and MT/start priority.
module tb_mdu_controller;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mdu_controller_if #(.WIDTH(32)) bus ();

  mdu_controller #(.WIDTH(32), .ITERS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.start    = 1'b0;
    bus.op       = MDU_MULT;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    bus.flush    = 1'b0;
    bus.mfhi_req = 1'b0;
    bus.mflo_req = 1'b0;
    bus.mthi_we  = 1'b0;
    bus.mtlo_we  = 1'b0;
  endtask

  task automatic test_reset_values;
    tests_run++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: hi=%h lo=%h busy=%b done=%b, want all zero",
               bus.hi_out, bus.lo_out, bus.busy, bus.done);
    end
  endtask

  // Issues one op and follows it for 36 cycles: exact done timing, busy length, result.
  task automatic run_op(input string name, input mdu_op_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    for (int c = 1; c <= 36; c++) begin
      tick;
      bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 34) begin
      tests_failed++;
      $display("FAIL %s_done: pulses=%0d at cycle %0d, want 1 at cycle 34", name, done_cnt, done_cyc);
    end
    tests_run++;
    if (busy_cnt !== 33) begin
      tests_failed++;
      $display("FAIL %s_busy: busy cycles=%0d, want 33", name, busy_cnt);
    end
    tests_run++;
    if (bus.hi_out !== exp_hi || bus.lo_out !== exp_lo) begin
      tests_failed++;
      $display("FAIL %s_result: hi=%h lo=%h, want hi=%h lo=%h", name, bus.hi_out, bus.lo_out, exp_hi, exp_lo);
    end
  endtask

  task automatic test_mult;
    run_op("mult_neg",   MDU_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max",  MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_min",   MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("mult_mixed", MDU_MULT,  32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD);
  endtask

  task automatic test_reset_midop;
    int done_cnt = 0;
    bus.start  = 1'b1;
    bus.op     = MDU_MULTU;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd3;
    tick;
    bus.start = 1'b0;
    repeat (5) tick;
    reset_n = 1'b0;
    tick;
    tick;
    tests_run++;
    if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midop: hi=%h lo=%h busy=%b done=%b, want all zero",
               bus.hi_out, bus.lo_out, bus.busy, bus.done);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (bus.done) done_cnt++;
    end
    tests_run++;
    if (done_cnt !== 0 || bus.lo_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_abandon: done pulses=%0d lo=%h, want 0 pulses lo=0", done_cnt, bus.lo_out);
    end
  endtask

  task automatic test_divide;
    run_op("div_neg",     MDU_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negdvsr", MDU_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_basic",  MDU_DIVU, 32'd100,      32'd7,        32'd2,        32'd14);
    run_op("divu_zero",   MDU_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_zero",    MDU_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf",     MDU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
  endtask

  // MULTU 3*5 with MFLO waiting from n+5; a start and MTLO at n+10 must be refused.
  task automatic test_stall;
    int stall_cnt = 0;
    int late_busy = 0;
    bus.start  = 1'b1;
    bus.op     = MDU_MULTU;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd5;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (c == 1) bus.start = 1'b0;
      if (c == 5) bus.mflo_req = 1'b1;
      if (c == 10) begin
        bus.start   = 1'b1;
        bus.op      = MDU_MULT;
        bus.rs_val  = 32'h0000DEAD;
        bus.rt_val  = 32'd2;
        bus.mtlo_we = 1'b1;
      end
      if (c == 11) begin
        bus.start   = 1'b0;
        bus.mtlo_we = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 33 && bus.stall === 1'b1) stall_cnt++;
      if (c == 34) begin
        tests_run++;
        if (bus.stall !== 1'b0 || bus.lo_out !== 32'd15 || bus.hi_out !== 32'd0) begin
          tests_failed++;
          $display("FAIL stall_release: stall=%b hi=%h lo=%h, want stall=0 hi=0 lo=0000000f",
                   bus.stall, bus.hi_out, bus.lo_out);
        end
        bus.mflo_req = 1'b0;
      end
      if (c >= 35 && bus.busy) late_busy++;
    end
    tests_run++;
    if (stall_cnt !== 29) begin
      tests_failed++;
      $display("FAIL stall_window: stalled cycles=%0d, want 29", stall_cnt);
    end
    tests_run++;
    if (late_busy !== 0 || bus.lo_out !== 32'd15) begin
      tests_failed++;
      $display("FAIL stall_refused: late busy=%0d lo=%h, want 0 and lo=0000000f", late_busy, bus.lo_out);
    end
  endtask

  // Flush at n+10 kills the op; then MTHI in IDLE and start+flush in IDLE.
  task automatic test_flush;
    int done_cnt = 0;
    bus.start  = 1'b1;
    bus.op     = MDU_MULT;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd3;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (c == 1) bus.start = 1'b0;
      if (bus.done) done_cnt++;
      if (c == 11) begin
        tests_run++;
        if (bus.busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL flush_busy: busy=%b at n+11, want 0", bus.busy);
        end
        bus.flush = 1'b0;
      end
      if (c == 10) bus.flush = 1'b1;
    end
    tests_run++;
    if (done_cnt !== 0 || bus.hi_out !== 32'd0 || bus.lo_out !== 32'd15) begin
      tests_failed++;
      $display("FAIL flush_keep: done pulses=%0d hi=%h lo=%h, want 0 pulses hi=0 lo=0000000f",
               done_cnt, bus.hi_out, bus.lo_out);
    end
    bus.mthi_we = 1'b1;
    bus.rs_val  = 32'h00001234;
    tick;
    bus.mthi_we = 1'b0;
    tests_run++;
    if (bus.hi_out !== 32'h00001234 || bus.lo_out !== 32'd15) begin
      tests_failed++;
      $display("FAIL mthi_idle: hi=%h lo=%h, want hi=00001234 lo=0000000f", bus.hi_out, bus.lo_out);
    end
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.op     = MDU_MULTU;
    bus.rs_val = 32'd9;
    bus.rt_val = 32'd9;
    tick;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_flush_idle: busy=%b, want 0", bus.busy);
    end
    repeat (36) tick;
    tests_run++;
    if (bus.lo_out !== 32'd15 || bus.hi_out !== 32'h00001234) begin
      tests_failed++;
      $display("FAIL start_flush_noop: hi=%h lo=%h, want hi=00001234 lo=0000000f", bus.hi_out, bus.lo_out);
    end
  endtask

  // MTLO in the same IDLE cycle as start is dropped; the op result lands later.
  task automatic test_mt_priority;
    bus.start   = 1'b1;
    bus.mtlo_we = 1'b1;
    bus.op      = MDU_MULTU;
    bus.rs_val  = 32'h00005555;
    bus.rt_val  = 32'd1;
    tick;
    bus.start   = 1'b0;
    bus.mtlo_we = 1'b0;
    tests_run++;
    if (bus.lo_out !== 32'd15 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mt_start_drop: lo=%h busy=%b, want lo=0000000f busy=1", bus.lo_out, bus.busy);
    end
    repeat (35) tick;
    tests_run++;
    if (bus.hi_out !== 32'd0 || bus.lo_out !== 32'h00005555) begin
      tests_failed++;
      $display("FAIL mt_start_result: hi=%h lo=%h, want hi=0 lo=00005555", bus.hi_out, bus.lo_out);
    end
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    test_reset_values();
    test_mult();
    test_reset_midop();
    test_divide();
    test_stall();
    test_flush();
    test_mt_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
